mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-port arbiter in front of the single-ported byte-addressed data memory. It shares the memory between the instruction-fetch requester and the load/store requester. Each cycle it issues at most one access to the memory and registers the read data and fault result back to the winning requester one cycle later. A memory fault halts all further grants until software or the trap unit clears it.

## Interface
- XLEN, 32, data/address width
- MAX_WAIT, 4, consecutive cycles a fetch request may lose arbitration before it is forced to win (≥1)
- clock  in  1  rising-edge clock
- reset_n  in  1  asynchronous active-low reset
- if_req  in  1  fetch request; hold with if_addr stable until if_ready
- if_addr  in  XLEN  fetch byte address (always word access, width 3'b010)
- if_ready  out  1  fetch granted this cycle (combinational)
- if_rvalid  out  1  registered: fetch response valid
- if_rdata  out  XLEN  registered fetch data
- if_fault  out  1  registered fetch fault flag
- d_req  in  1  data request; hold with d_* stable until d_ready
- d_we  in  1  1 = store, 0 = load
- d_addr  in  XLEN  data byte address
- d_wdata  in  XLEN  store data
- d_width  in  3  0 = byte, 1 = half, 2 = word
- d_ready  out  1  data granted this cycle (combinational)
- d_rvalid  out  1  registered: data response valid (loads and stores)
- d_rdata  out  XLEN  registered load data (0 for stores)
- d_fault  out  1  registered data fault flag
- mem_addr, mem_wdata  out  XLEN  to memory
- mem_width  out  3  to memory
- mem_read_en, mem_write_en  out  1  to memory; never both high
- mem_valM  in  XLEN  combinational read data from memory
- mem_fault  in  1  combinational fault from memory
- fault_clear  in  1  leave HALT
- halted  out  1  registered: arbiter is in HALT

## Operation
- States: RUN, HALT. Reset → RUN.
- RUN grant rules (combinational):
  - Only d_req: data wins.
  - Only if_req: fetch wins.
  - Both: data wins unless wait_cnt == MAX_WAIT, in which case fetch wins.
  - Neither: no grant. mem_read_en = mem_write_en = 0, and mem_addr/wdata/width = 0.
- Fetch grant drives mem_addr = if_addr, mem_width = 3'b010, mem_read_en = 1, mem_wdata = 0.
- Data grant drives mem_addr = d_addr, mem_width = d_width, mem_wdata = d_wdata, and mem_write_en = d_we, mem_read_en = !d_we.
- wait_cnt, width clog2(MAX_WAIT+1):
  - Increments, saturating at MAX_WAIT, in cycles where if_req = 1 and fetch is not granted.
  - Clears to 0 when fetch is granted or when if_req = 0.
- On each accepted request, register the following into the winner's response:
  - rvalid = 1
  - rdata = mem_valM for a load/fetch, 0 for a store
  - fault = mem_fault
- The loser's rvalid is 0 that cycle.
- If the accepted access has mem_fault = 1, go to HALT at that edge. The memory itself suppresses a faulting write.
- HALT:
  - if_ready = d_ready = 0; memory enables 0; wait_cnt held.
  - fault_clear = 1 → RUN at the next edge. Grants resume the cycle after.
- fault_clear in RUN is ignored.

## Timing
- Grant latency 0: ready is asserted in the same cycle as req when the request wins.
- Response latency 1: rvalid, rdata and fault appear the cycle after the accepted edge and stay high exactly one cycle unless a new access is accepted.
- Store data reaches memory on the accepted edge. A load issued in the next cycle to the same address returns the new data.
- Throughput is one access per cycle. Back-to-back grants to the same port are allowed.
- Reset values: every registered output (if_rvalid, if_rdata, if_fault, d_rvalid, d_rdata, d_fault, halted) is 0; state = RUN; wait_cnt = 0.
- Combinational outputs follow the rules above.
- reset_n asserted mid-access: the pending response is discarded, with no rvalid after release.
- Requests in the first cycle after reset release are arbitrated normally.
- Fault and fault_clear in the same cycle while in RUN: enter HALT; the clear is ignored.

## Test plan
- Fetch only: if_req = 1, if_addr = 0x100, mem word 0x100 = 0xDEADBEEF → if_ready same cycle; next cycle if_rvalid = 1, if_rdata = 0xDEADBEEF, if_fault = 0.
- Store then load:
  - d_we = 1, d_addr = 0x40, d_width = 0, d_wdata = 0xA5 → d_rvalid next cycle with d_rdata = 0.
  - Then load word 0x40 → d_rdata[7:0] = 0xA5.
- Starvation with MAX_WAIT = 4: if_req and d_req held high continuously → data granted cycles 0-3, fetch granted cycle 4, wait_cnt back to 0, data granted cycle 5.
- Fault halt:
  - Data load at d_addr = 0 → d_fault = 1 next cycle and halted = 1.
  - Subsequent requests get no ready for 3 cycles.
  - Pulse fault_clear → halted = 0 and the next request is granted.
- Reset mid-operation: assert reset_n = 0 in the cycle a load is granted → no d_rvalid after release; all registered outputs 0.
- Idle: no requests → mem_read_en = mem_write_en = 0 every cycle and both rvalids stay 0.

Source files
------------

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the fetch/load-store requesters, the arbiter
// and the single-ported data memory.
interface mem_arbiter_if #(
    parameter int XLEN = 32
);
    logic            if_req;
    logic [XLEN-1:0] if_addr;
    logic            if_ready;
    logic            if_rvalid;
    logic [XLEN-1:0] if_rdata;
    logic            if_fault;

    logic            d_req;
    logic            d_we;
    logic [XLEN-1:0] d_addr;
    logic [XLEN-1:0] d_wdata;
    logic [2:0]      d_width;
    logic            d_ready;
    logic            d_rvalid;
    logic [XLEN-1:0] d_rdata;
    logic            d_fault;

    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_wdata;
    logic [2:0]      mem_width;
    logic            mem_read_en;
    logic            mem_write_en;
    logic [XLEN-1:0] mem_valM;
    logic            mem_fault;

    logic            fault_clear;
    logic            halted;

    modport slave (
        input  if_req, if_addr,
        output if_ready, if_rvalid, if_rdata, if_fault,
        input  d_req, d_we, d_addr, d_wdata, d_width,
        output d_ready, d_rvalid, d_rdata, d_fault,
        output mem_addr, mem_wdata, mem_width, mem_read_en, mem_write_en,
        input  mem_valM, mem_fault,
        input  fault_clear,
        output halted
    );

    modport master (
        output if_req, if_addr,
        input  if_ready, if_rvalid, if_rdata, if_fault,
        output d_req, d_we, d_addr, d_wdata, d_width,
        input  d_ready, d_rvalid, d_rdata, d_fault,
        input  mem_addr, mem_wdata, mem_width, mem_read_en, mem_write_en,
        output mem_valM, mem_fault,
        output fault_clear,
        input  halted
    );
endinterface

// File: rtl/mem_arbiter.sv
// Fetch / load-store arbiter for the shared data memory, with
// fetch anti-starvation and halt-on-fault.
module mem_arbiter #(
    parameter int XLEN     = 32,
    parameter int MAX_WAIT = 4
) (
    input  logic          clock,
    input  logic          reset_n,
    mem_arbiter_if.slave  bus
);
    localparam int WW = $clog2(MAX_WAIT + 1);

    typedef enum logic {RUN, HALT} state_t;

    state_t        r_state;
    logic [WW-1:0] r_wait_cnt;

    logic w_run;
    logic w_if_win;
    logic w_d_win;
    logic w_accept;

    assign w_run    = (r_state == RUN);
    // Data normally wins; a fetch that has lost MAX_WAIT times in a row wins.
    assign w_if_win = w_run && bus.if_req &&
                      (!bus.d_req || r_wait_cnt == WW'(MAX_WAIT));
    assign w_d_win  = w_run && bus.d_req && !w_if_win;
    assign w_accept = w_if_win || w_d_win;

    assign bus.if_ready = w_if_win;
    assign bus.d_ready  = w_d_win;

    always_comb begin
        bus.mem_addr     = '0;
        bus.mem_wdata    = '0;
        bus.mem_width    = 3'b000;
        bus.mem_read_en  = 1'b0;
        bus.mem_write_en = 1'b0;
        unique case (1'b1)
            w_if_win: begin
                bus.mem_addr    = bus.if_addr;
                bus.mem_width   = 3'b010;
                bus.mem_read_en = 1'b1;
            end
            w_d_win: begin
                bus.mem_addr     = bus.d_addr;
                bus.mem_width    = bus.d_width;
                bus.mem_wdata    = bus.d_wdata;
                bus.mem_write_en = bus.d_we;
                bus.mem_read_en  = !bus.d_we;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            r_state       <= RUN;
            r_wait_cnt    <= '0;
            bus.halted    <= 1'b0;
            bus.if_rvalid <= 1'b0;
            bus.if_rdata  <= '0;
            bus.if_fault  <= 1'b0;
            bus.d_rvalid  <= 1'b0;
            bus.d_rdata   <= '0;
            bus.d_fault   <= 1'b0;
        end else begin
            bus.if_rvalid <= w_if_win;
            bus.if_rdata  <= w_if_win ? bus.mem_valM : '0;
            bus.if_fault  <= w_if_win && bus.mem_fault;
            bus.d_rvalid  <= w_d_win;
            bus.d_rdata   <= (w_d_win && !bus.d_we) ? bus.mem_valM : '0;
            bus.d_fault   <= w_d_win && bus.mem_fault;

            case (r_state)
                RUN: begin
                    if (!bus.if_req || w_if_win)
                        r_wait_cnt <= '0;
                    else if (r_wait_cnt != WW'(MAX_WAIT))
                        r_wait_cnt <= r_wait_cnt + 1'b1;
                    if (w_accept && bus.mem_fault) begin
                        r_state    <= HALT;
                        bus.halted <= 1'b1;
                    end
                end
                HALT: begin
                    if (bus.fault_clear) begin
                        r_state    <= RUN;
                        bus.halted <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= RUN;
                    bus.halted <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a byte-addressed memory model
// that faults on any access to address 0.
module tb_mem_arbiter;
    localparam int XLEN = 32;

    logic clock;
    logic reset_n;
    int   n_checks;
    int   n_errors;

    mem_arbiter_if #(.XLEN(XLEN)) bus ();

    mem_arbiter #(.XLEN(XLEN), .MAX_WAIT(4)) dut (
        .clock   (clock),
        .reset_n (reset_n),
        .bus     (bus.slave)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    logic [7:0] mem [0:1023];
    logic [9:0] ma;

    assign ma = bus.mem_addr[9:0];

    always_comb begin
        bus.mem_valM = '0;
        case (bus.mem_width)
            3'b000:  bus.mem_valM = {24'h0, mem[ma]};
            3'b001:  bus.mem_valM = {16'h0, mem[ma + 10'd1], mem[ma]};
            default: bus.mem_valM = {mem[ma + 10'd3], mem[ma + 10'd2],
                                     mem[ma + 10'd1], mem[ma]};
        endcase
    end

    assign bus.mem_fault = (bus.mem_read_en || bus.mem_write_en) &&
                           (bus.mem_addr == '0);

    always @(posedge clock) begin
        if (bus.mem_write_en && !bus.mem_fault) begin
            mem[ma] <= bus.mem_wdata[7:0];
            if (bus.mem_width != 3'b000)
                mem[ma + 10'd1] <= bus.mem_wdata[15:8];
            if (bus.mem_width == 3'b010) begin
                mem[ma + 10'd2] <= bus.mem_wdata[23:16];
                mem[ma + 10'd3] <= bus.mem_wdata[31:24];
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs();
        bus.if_req      = 1'b0;
        bus.if_addr     = '0;
        bus.d_req       = 1'b0;
        bus.d_we        = 1'b0;
        bus.d_addr      = '0;
        bus.d_wdata     = '0;
        bus.d_width     = 3'b000;
        bus.fault_clear = 1'b0;
    endtask

    task automatic d_load(input logic [31:0] a);
        bus.d_req   = 1'b1;
        bus.d_we    = 1'b0;
        bus.d_addr  = a;
        bus.d_width = 3'b010;
        bus.d_wdata = '0;
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
        mem[10'h100] = 8'hEF;
        mem[10'h101] = 8'hBE;
        mem[10'h102] = 8'hAD;
        mem[10'h103] = 8'hDE;
        idle_inputs();
        reset_n = 1'b0;
        tick();
        tick();
        chk("rst_halted", {31'h0, bus.halted}, 32'h0);
        chk("rst_if_rvalid", {31'h0, bus.if_rvalid}, 32'h0);
        chk("rst_d_rvalid", {31'h0, bus.d_rvalid}, 32'h0);
        chk("rst_if_rdata", bus.if_rdata, 32'h0);
        chk("rst_d_rdata", bus.d_rdata, 32'h0);
        reset_n = 1'b1;

        for (int c = 0; c < 3; c++) begin
            #1;
            chk("idle_en", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
            chk("idle_rv", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
            tick();
        end

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        #1;
        chk("f_ready", {31'h0, bus.if_ready}, 32'h1);
        chk("f_mem_addr", bus.mem_addr, 32'h100);
        chk("f_mem_w", {29'h0, bus.mem_width}, 32'h2);
        chk("f_rd_en", {31'h0, bus.mem_read_en}, 32'h1);
        tick();
        idle_inputs();
        chk("f_rvalid", {31'h0, bus.if_rvalid}, 32'h1);
        chk("f_rdata", bus.if_rdata, 32'hDEADBEEF);
        chk("f_fault", {31'h0, bus.if_fault}, 32'h0);
        chk("f_d_rvalid", {31'h0, bus.d_rvalid}, 32'h0);
        tick();
        chk("f_rvalid_1cyc", {31'h0, bus.if_rvalid}, 32'h0);

        bus.d_req   = 1'b1;
        bus.d_we    = 1'b1;
        bus.d_addr  = 32'h40;
        bus.d_width = 3'b000;
        bus.d_wdata = 32'hA5;
        #1;
        chk("st_ready", {31'h0, bus.d_ready}, 32'h1);
        chk("st_en", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h1);
        tick();
        chk("st_rvalid", {31'h0, bus.d_rvalid}, 32'h1);
        chk("st_rdata", bus.d_rdata, 32'h0);
        d_load(32'h40);
        #1;
        chk("ld_ready", {31'h0, bus.d_ready}, 32'h1);
        tick();
        idle_inputs();
        chk("ld_rvalid", {31'h0, bus.d_rvalid}, 32'h1);
        chk("ld_rdata", bus.d_rdata, 32'h000000A5);
        tick();

        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        d_load(32'h40);
        for (int c = 0; c < 6; c++) begin
            #1;
            chk($sformatf("starve_if_c%0d", c), {31'h0, bus.if_ready},
                {31'h0, c == 4});
            chk($sformatf("starve_d_c%0d", c), {31'h0, bus.d_ready},
                {31'h0, c != 4});
            tick();
            if (c == 4)
                chk("starve_if_rdata", bus.if_rdata, 32'hDEADBEEF);
        end
        idle_inputs();
        tick();

        d_load(32'h0);
        #1;
        chk("flt_ready", {31'h0, bus.d_ready}, 32'h1);
        tick();
        chk("flt_d_fault", {31'h0, bus.d_fault}, 32'h1);
        chk("flt_d_rvalid", {31'h0, bus.d_rvalid}, 32'h1);
        chk("flt_halted", {31'h0, bus.halted}, 32'h1);
        bus.if_req  = 1'b1;
        bus.if_addr = 32'h100;
        d_load(32'h40);
        for (int c = 0; c < 3; c++) begin
            #1;
            chk("halt_ready", {30'h0, bus.if_ready, bus.d_ready}, 32'h0);
            chk("halt_en", {30'h0, bus.mem_read_en, bus.mem_write_en}, 32'h0);
            tick();
            chk("halt_rv", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
        end
        bus.if_req      = 1'b0;
        bus.fault_clear = 1'b1;
        #1;
        chk("clr_cyc_ready", {31'h0, bus.d_ready}, 32'h0);
        tick();
        bus.fault_clear = 1'b0;
        chk("clr_halted", {31'h0, bus.halted}, 32'h0);
        #1;
        chk("clr_ready", {31'h0, bus.d_ready}, 32'h1);
        tick();
        idle_inputs();
        chk("clr_rdata", bus.d_rdata, 32'h000000A5);
        tick();

        d_load(32'h0);
        bus.fault_clear = 1'b1;
        tick();
        idle_inputs();
        chk("flt_clr_same", {31'h0, bus.halted}, 32'h1);
        bus.fault_clear = 1'b1;
        tick();
        bus.fault_clear = 1'b0;
        chk("flt_clr_exit", {31'h0, bus.halted}, 32'h0);

        d_load(32'h40);
        #1;
        chk("rst_mid_ready", {31'h0, bus.d_ready}, 32'h1);
        #1;
        reset_n = 1'b0;
        tick();
        idle_inputs();
        chk("rst_mid_rvalid", {31'h0, bus.d_rvalid}, 32'h0);
        chk("rst_mid_rdata", bus.d_rdata, 32'h0);
        chk("rst_mid_fault", {30'h0, bus.d_fault, bus.if_fault}, 32'h0);
        reset_n = 1'b1;
        tick();
        chk("rst_rel_rvalid", {30'h0, bus.if_rvalid, bus.d_rvalid}, 32'h0);
        chk("rst_rel_halted", {31'h0, bus.halted}, 32'h0);
        d_load(32'h40);
        #1;
        chk("post_rst_ready", {31'h0, bus.d_ready}, 32'h1);
        tick();
        idle_inputs();
        chk("post_rst_rdata", bus.d_rdata, 32'h000000A5);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end
endmodule
